mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 159 +++++++++++++++
 tb/tb_mem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port-style word RAM serving instruction fetch,
// byte/half/word stores and fixed-latency, lane-aligned loads.
//
// Ports:
//   clk, rst (async, active high), clk_en (global stall)
//   i_read_fetch_addr -> o_read_fetch_data   : word fetch, 1-cycle latency
//   i_read_req, i_read_addr -> o_read_data,
//     o_read_ready                           : load, READ_LATENCY handshake
//   i_write_enable, i_byte_enable,
//     i_write_addr, i_write_data             : lane-0 relative store
//   o_error                                  : sticky bad-access flag
module mem_responder #(
  parameter int    ADDR_WIDTH   = 31,
  parameter int    DATA_WIDTH   = 31,
  parameter int    DEPTH_LOG2   = 10,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [ADDR_WIDTH:0]   i_read_fetch_addr,
  output logic [DATA_WIDTH:0]   o_read_fetch_data,
  input  logic                  i_read_req,
  input  logic [ADDR_WIDTH:0]   i_read_addr,
  output logic [DATA_WIDTH:0]   o_read_data,
  output logic                  o_read_ready,
  input  logic                  i_write_enable,
  input  logic [3:0]            i_byte_enable,
  input  logic [ADDR_WIDTH:0]   i_write_addr,
  input  logic [DATA_WIDTH:0]   i_write_data,
  output logic                  o_error
);

  localparam int IW    = DEPTH_LOG2;
  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  if (DATA_WIDTH != 31) begin : g_bad_dw
    $error("mem_responder: DATA_WIDTH must be 31");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("mem_responder: READ_LATENCY must be 1..4");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  logic [DATA_WIDTH:0] mem [WORDS];

  // Fetch ignores address bits above the RAM index.
  logic unused_fetch_hi;
  assign unused_fetch_hi = ^i_read_fetch_addr[ADDR_WIDTH:IW];

  // ---------------- store path ----------------
  logic [1:0]    w_off;
  logic [IW-1:0] w_idx;
  logic          w_oor;
  logic          w_mis;
  logic          w_ok;
  logic          w_err;
  logic [7:0]    be_sh;
  logic [31:0]   wd_sh;

  assign w_off = i_write_addr[1:0];
  assign w_idx = i_write_addr[IW+1:2];
  assign w_oor = |i_write_addr[ADDR_WIDTH:IW+2];
  assign be_sh = {4'b0000, i_byte_enable} << w_off;
  assign wd_sh = i_write_data << {w_off, 3'b000};

  // Any enable pushed past lane 3 would straddle two words.
  assign w_mis = (i_byte_enable == 4'b0011 && w_off[0])
              || (i_byte_enable == 4'b1111 && w_off != 2'd0)
              || (|be_sh[7:4]);
  assign w_ok  = i_write_enable & ~w_oor & ~w_mis;
  assign w_err = i_write_enable & (w_oor | w_mis);

  always_ff @(posedge clk) begin
    if (clk_en && w_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be_sh[i]) mem[w_idx][8*i +: 8] <= wd_sh[8*i +: 8];
      end
    end
  end

  // ---------------- load FSM ----------------
  state_t        state, state_d;
  logic [1:0]    cnt, cnt_d;
  logic [IW-1:0] ld_idx;
  logic [1:0]    ld_off;
  logic          ld_oor;
  logic          rdy_q;
  logic          accept, done;
  logic          r_oor;
  logic [31:0]   ld_shift;

  assign r_oor    = |i_read_addr[ADDR_WIDTH:IW+2];
  assign ld_shift = mem[ld_idx] >> {ld_off, 3'b000};

  // State register plus the datapath registers it steers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      ld_idx            <= '0;
      ld_off            <= '0;
      ld_oor            <= 1'b0;
      rdy_q             <= 1'b0;
      o_read_data       <= '0;
      o_read_fetch_data <= '0;
      o_error           <= 1'b0;
    end else if (clk_en) begin
      state             <= state_d;
      cnt               <= cnt_d;
      rdy_q             <= done;
      o_read_fetch_data <= mem[i_read_fetch_addr[IW-1:0]];
      if (accept) begin
        ld_idx <= i_read_addr[IW+1:2];
        ld_off <= i_read_addr[1:0];
        ld_oor <= r_oor;
      end
      // RAM sampled here sees the pre-store value on a same-edge write.
      if (done) o_read_data <= ld_oor ? '0 : ld_shift;
      if (w_err || (accept && r_oor)) o_error <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_read_req) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt == 2'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: a pending ready is held across stalls and shown
  // only in an enabled cycle, so it stays a single-cycle pulse.
  always_comb begin
    o_read_ready = rdy_q & clk_en;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder.
// Stimulus pushes expectations; negedge monitors pop and compare.
module tb_mem_responder;

  localparam int LAT = 3;
  localparam int DL  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [31:0] fetch_addr;
  logic [31:0] f_data;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_ready;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pulses  = 0;

  logic [31:0] sb[$];
  logic [31:0] fq[$];
  logic        fetch_mark = 1'b0;
  logic        fetch_live = 1'b0;

  mem_responder #(
    .ADDR_WIDTH(31), .DATA_WIDTH(31),
    .DEPTH_LOG2(DL), .READ_LATENCY(LAT),
    .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_read_fetch_addr(fetch_addr),
    .o_read_fetch_data(f_data),
    .i_read_req(rd_req),
    .i_read_addr(rd_addr),
    .o_read_data(rd_data),
    .o_read_ready(rd_ready),
    .i_write_enable(we),
    .i_byte_enable(be),
    .i_write_addr(wr_addr),
    .i_write_data(wr_data),
    .o_error(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    fetch_live <= fetch_mark;
  end

  always @(negedge clk) begin
    if (rd_ready === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: data %08h", rd_data);
      end else begin
        check("load_data", rd_data, sb.pop_front());
      end
    end
    if (fetch_live) begin
      if (fq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fetch_extra: data %08h", f_data);
      end else begin
        check("fetch_data", f_data, fq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [3:0]  b,
                       input logic [31:0] d);
    wr_addr = a;
    be      = b;
    wr_data = d;
    we      = 1'b1;
    tick();
    we      = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a,
                         input logic [31:0] exp,
                         input int stall,
                         input int lat);
    int c0;
    bit seen;
    seen = 1'b0;
    sb.push_back(exp);
    rd_addr = a;
    rd_req  = 1'b1;
    c0      = cyc;
    if (stall > 0) begin
      tick();
      tick();
      clk_en = 1'b0;
      repeat (stall) tick();
      clk_en = 1'b1;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    rd_req = 1'b0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL load_timeout: addr %08h no ready", a);
      sb.delete();
    end else begin
      check("load_latency", cyc - c0, lat);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    rst        = 1'b1;
    clk_en     = 1'b1;
    fetch_addr = '0;
    rd_req     = 1'b0;
    rd_addr    = '0;
    we         = 1'b0;
    be         = '0;
    wr_addr    = '0;
    wr_data    = '0;

    repeat (2) @(negedge clk);
    check("rst_fetch", f_data, 32'h0);
    check("rst_rdata", rd_data, 32'h0);
    check("rst_ready", {31'b0, rd_ready}, 32'h0);
    check("rst_error", {31'b0, err}, 32'h0);
    tick();
    rst = 1'b0;

    store(32'd0,  4'hF, 32'h0000_0013);
    store(32'd4,  4'hF, 32'h00A0_0093);
    store(32'd8,  4'hF, 32'h1122_3344);
    store(32'd12, 4'hF, 32'hDEAD_BEEF);

    fetch_mark = 1'b1;
    fetch_addr = 32'd0;
    fq.push_back(32'h0000_0013);
    tick();
    fetch_addr = 32'd1;
    fq.push_back(32'h00A0_0093);
    tick();
    fetch_addr = 32'd2;
    fq.push_back(32'h1122_3344);
    tick();
    fetch_mark = 1'b0;
    tick();

    store(32'd9, 4'b0001, 32'h0000_00AB);
    do_load(32'd8,  32'h1122_AB44, 0, LAT + 1);
    do_load(32'd14, 32'h0000_DEAD, 0, LAT + 1);
    check("err_clean", {31'b0, err}, 32'h0);

    // Held request: one pulse per accepted load.
    p0 = pulses;
    sb.push_back(32'h0000_DEAD);
    sb.push_back(32'h0000_DEAD);
    rd_addr = 32'd14;
    rd_req  = 1'b1;
    repeat (2 * (LAT + 1)) tick();
    rd_req = 1'b0;
    repeat (3) tick();
    check("held_pulses", pulses - p0, 32'd2);

    store(32'd6, 4'hF, 32'hCAFE_F00D);
    check("err_misalign", {31'b0, err}, 32'h1);
    do_load(32'd4, 32'h00A0_0093, 0, LAT + 1);

    store(32'd4 << DL, 4'hF, 32'hFFFF_FFFF);
    do_load(32'd0, 32'h0000_0013, 0, LAT + 1);
    check("err_sticky", {31'b0, err}, 32'h1);

    // Store lands on the same edge the load completes.
    sb.push_back(32'hDEAD_BEEF);
    rd_addr = 32'd12;
    rd_req  = 1'b1;
    repeat (LAT) tick();
    wr_addr = 32'd12;
    be      = 4'hF;
    wr_data = 32'h5566_7788;
    we      = 1'b1;
    tick();
    we = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    check("coll_ready", {31'b0, rd_ready}, 32'h1);
    tick();
    do_load(32'd12, 32'h5566_7788, 0, LAT + 1);

    do_load(32'd8, 32'h1122_AB44, 2, LAT + 3);

    // Reset while busy drops the load.
    p0 = pulses;
    rd_addr = 32'd12;
    rd_req  = 1'b1;
    tick();
    tick();
    rst    = 1'b1;
    rd_req = 1'b0;
    @(negedge clk);
    check("mid_rst_fetch", f_data, 32'h0);
    check("mid_rst_rdata", rd_data, 32'h0);
    check("mid_rst_ready", {31'b0, rd_ready}, 32'h0);
    check("mid_rst_error", {31'b0, err}, 32'h0);
    tick();
    rst = 1'b0;
    repeat (LAT + 3) tick();
    check("mid_rst_pulses", pulses - p0, 32'd0);

    store(32'd2, 4'b0011, 32'h0000_BEEF);
    store(32'd0, 4'b0000, 32'hFFFF_FFFF);
    do_load(32'd2,  32'h0000_BEEF, 0, LAT + 1);
    do_load(32'd0,  32'hBEEF_0013, 0, LAT + 1);
    do_load(32'd13, 32'h0055_6677, 0, LAT + 1);
    check("err_after_rst", {31'b0, err}, 32'h0);
    do_load(32'd4 << DL, 32'h0000_0000, 0, LAT + 1);
    check("err_oor_load", {31'b0, err}, 32'h1);

    repeat (2) tick();
    check("sb_empty", sb.size(), 32'd0);
    check("fq_empty", fq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
